// File: rtl/funct_generator_pkg.sv
// Shared types and helpers for the function generator sample loader.
package funct_generator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } loader_state_t;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 6;

    // A load length is usable when it is non-zero and fits the 2^aw sample RAM.
    function automatic logic len_ok(input logic [31:0] len, input int unsigned aw);
        return (len != 32'd0) && (len <= (32'd1 << aw));
    endfunction

endpackage

// File: rtl/loader_cnt.sv
// Up-counter with synchronous clear and count enable; clear has priority.
module loader_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Count register; reset and clear both return to zero.
    always_ff @(posedge clk) begin
        if (!rst_n)      cnt_q <= '0;
        else if (clr_i)  cnt_q <= '0;
        else if (en_i)   cnt_q <= cnt_q + W'(1);
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/funct_generator_loader.sv
// Drains waveform samples from the upstream FIFO into the generator sample RAM,
// holds the generator in configuration while loading, then releases it to run.
// Optional FIFO-starvation timeout: define LOADER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | generator disabled, waiting for start_i
// LOAD  | popping FIFO and writing sample RAM, generator held in configure
// RUN   | samples loaded, generator running
module funct_generator_loader
    import funct_generator_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic [AW:0]   len_i,
    input  logic          fifo_empty_i,
    input  logic [DW-1:0] fifo_data_i,
    output logic          fifo_rd_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_data_o,
    output logic          enh_conf_o,
    output logic          en_low_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    loader_state_t state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   rd_cnt, wr_cnt;
    logic          rd_q;
    logic          load_go;
    logic          start_ok;
    logic          last_wr;
    logic          tmo_hit;
    logic          enh_conf_q, enh_conf_d;
    logic          en_low_q, en_low_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    assign start_ok = len_ok(32'(len_i), AW);
    assign last_wr  = rd_q && (wr_cnt == (len_q - (AW+1)'(1)));

    // Pop strobe; gated by reset so a reset cycle never consumes a sample.
    assign fifo_rd_o = rst_n && (state_q == LOAD) && !fifo_empty_i
                       && (rd_cnt < len_q) && !stop_i && !tmo_hit;

    // RAM write follows the pop by one cycle; data passes straight from the FIFO.
    assign mem_we_o   = rst_n && rd_q;
    assign mem_addr_o = mem_we_o ? wr_cnt[AW-1:0] : '0;
    assign mem_data_o = mem_we_o ? fifo_data_i : '0;

    loader_cnt #(.W(AW+1)) u_rd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (load_go),
        .en_i  (fifo_rd_o),
        .cnt_o (rd_cnt)
    );

    loader_cnt #(.W(AW+1)) u_wr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (load_go),
        .en_i  (mem_we_o),
        .cnt_o (wr_cnt)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] tmo_cnt;

    loader_cnt #(.W(TW)) u_tmo_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (load_go || fifo_rd_o || (state_q != LOAD)),
        .en_i  ((state_q == LOAD) && fifo_empty_i && (rd_cnt < len_q) && !tmo_hit),
        .cnt_o (tmo_cnt)
    );

    assign tmo_hit = (state_q == LOAD) && (tmo_cnt == TW'(TMO));
`else
    assign tmo_hit = 1'b0;
`endif

    // Next state and registered output values; stop_i outranks start_i everywhere.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        load_go = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (start_i) begin
                    if (start_ok) begin
                        state_d = LOAD;
                        len_d   = len_i;
                        load_go = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (last_wr) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        enh_conf_d = (state_d == LOAD);
        en_low_d   = (state_d != RUN);
        busy_d     = (state_d == LOAD);
    end

    // State, latched length, pop pipeline and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            rd_q       <= 1'b0;
            enh_conf_q <= 1'b0;
            en_low_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_q       <= fifo_rd_o;
            enh_conf_q <= enh_conf_d;
            en_low_q   <= en_low_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign enh_conf_o = enh_conf_q;
    assign en_low_o   = en_low_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_funct_generator_loader.sv
// Directed bench for funct_generator_loader with a simple FIFO model and a
// monitor that mirrors RAM writes into a local array.
module tb_funct_generator_loader;

    localparam int DW = 8;
    localparam int AW = 6;
`ifdef LOADER_TIMEOUT_EN
    localparam int TB_TMO = 5;
`else
    localparam int TB_TMO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic [AW:0]   len_i = '0;
    logic          fifo_empty_i;
    logic [DW-1:0] fifo_data_i = '0;
    logic          fifo_rd_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic          enh_conf_o;
    logic          en_low_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int n_checks = 0;
    int n_fail   = 0;

    funct_generator_loader #(.DW(DW), .AW(AW), .TMO(TB_TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .len_i        (len_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_rd_o    (fifo_rd_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .enh_conf_o   (enh_conf_o),
        .en_low_o     (en_low_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    // FIFO model: pushes from the stimulus process, pops on the DUT strobe.
    logic [DW-1:0] fifo_mem [0:255];
    int wp = 0;
    int rp = 0;
    assign fifo_empty_i = (wp == rp);

    always @(posedge clk) begin
        if (fifo_rd_o) begin
            fifo_data_i <= fifo_mem[rp[7:0]];
            rp <= rp + 1;
        end
    end

    // Monitor: record writes and count strobes away from the active edge.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    int wr_n = 0, rd_n = 0, done_n = 0, err_n = 0;
    int last_addr = -1;

    always @(negedge clk) begin
        if (mem_we_o) begin
            sram[mem_addr_o] <= mem_data_o;
            wr_n      <= wr_n + 1;
            last_addr <= int'(mem_addr_o);
        end
        if (fifo_rd_o) rd_n   <= rd_n + 1;
        if (done_o)    done_n <= done_n + 1;
        if (err_o)     err_n  <= err_n + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        fifo_mem[wp[7:0]] = d;
        wp = wp + 1;
    endtask

    task automatic pulse_start(input logic [AW:0] len);
        start_i = 1'b1;
        len_i   = len;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done_o) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wb, rb, db, eb;
        bit ok;

        // Reset values
        push(8'h10); push(8'h11); push(8'h12); push(8'h13);
        tick(); tick();
        @(negedge clk);
        check_val("rst_fifo_rd", fifo_rd_o, 0);
        check_val("rst_we", mem_we_o, 0);
        check_val("rst_enh", enh_conf_o, 0);
        check_val("rst_en_low", en_low_o, 1);
        check_val("rst_busy", busy_o, 0);
        rst_n = 1'b1;
        tick();

        // Basic load of four samples
        wb = wr_n; db = done_n;
        pulse_start(7'd4);
        check_val("basic_busy", busy_o, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("basic_pop", fifo_rd_o, 1);
            check_val("basic_enh", enh_conf_o, 1);
            tick();
        end
        @(negedge clk);
        check_val("basic_last_we", mem_we_o, 1);
        check_val("basic_last_addr", mem_addr_o, 3);
        check_val("basic_last_pop", fifo_rd_o, 0);
        tick();
        check_val("basic_done", done_o, 1);
        check_val("basic_run_enh", enh_conf_o, 0);
        check_val("basic_run_en_low", en_low_o, 0);
        tick();
        check_val("basic_done_once", done_o, 0);
        check_val("basic_writes", wr_n - wb, 4);
        check_val("basic_done_cnt", done_n - db, 1);
        for (int i = 0; i < 4; i++)
            check_val("basic_data", sram[i], 8'h10 + i);

        // Leave RUN, then bad lengths from IDLE
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        check_val("stop_run_en_low", en_low_o, 1);
        push(8'hA0);
        rb = rd_n; eb = err_n;
        pulse_start(7'd0);
        check_val("bad0_err", err_o, 1);
        check_val("bad0_busy", busy_o, 0);
        tick();
        check_val("bad0_err_pulse", err_o, 0);
        pulse_start(7'd65);
        check_val("bad65_err", err_o, 1);
        check_val("bad65_enh", enh_conf_o, 0);
        tick();
        check_val("bad_err_cnt", err_n - eb, 2);
        check_val("bad_no_pop", rd_n - rb, 0);

        // Starved FIFO: one sample present, len 3
        wb = wr_n; eb = err_n;
        pulse_start(7'd3);
`ifdef LOADER_TIMEOUT_EN
        ok = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (err_o) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        check_val("tmo_err_seen", ok, 1);
        check_val("tmo_idle_busy", busy_o, 0);
        check_val("tmo_idle_en_low", en_low_o, 1);
        check_val("tmo_one_write", wr_n - wb, 1);
`else
        for (int i = 0; i < 10; i++) tick();
        check_val("starve_one_write", wr_n - wb, 1);
        check_val("starve_still_busy", busy_o, 1);
        check_val("starve_no_err", err_n - eb, 0);
        push(8'hA1); push(8'hA2);
        wait_done(30, ok);
        check_val("starve_done", ok, 1);
        check_val("starve_writes", wr_n - wb, 3);
        check_val("starve_d0", sram[0], 8'hA0);
        check_val("starve_d1", sram[1], 8'hA1);
        check_val("starve_d2", sram[2], 8'hA2);
`endif

        // start_i and stop_i together: stop wins
        start_i = 1'b1; stop_i = 1'b1; len_i = 7'd2;
        @(negedge clk);
        check_val("both_no_pop", fifo_rd_o, 0);
        tick();
        start_i = 1'b0; stop_i = 1'b0;
        check_val("both_en_low", en_low_o, 1);
        check_val("both_enh", enh_conf_o, 0);
        check_val("both_busy", busy_o, 0);

        // Abort after two pops
        push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
        wb = wr_n; rb = rd_n; db = done_n;
        pulse_start(7'd4);
        tick(); tick();
        stop_i = 1'b1;
        @(negedge clk);
        check_val("abort_no_pop", fifo_rd_o, 0);
        check_val("abort_we", mem_we_o, 1);
        check_val("abort_addr", mem_addr_o, 1);
        check_val("abort_data", mem_data_o, 8'hB1);
        tick();
        stop_i = 1'b0;
        check_val("abort_busy", busy_o, 0);
        check_val("abort_en_low", en_low_o, 1);
        tick();
        check_val("abort_writes", wr_n - wb, 2);
        check_val("abort_pops", rd_n - rb, 2);
        check_val("abort_no_done", done_n - db, 0);

        // Reset with a pop in flight
        wb = wr_n;
        pulse_start(7'd4);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check_val("rstmid_no_we", mem_we_o, 0);
        check_val("rstmid_no_pop", fifo_rd_o, 0);
        tick();
        rst_n = 1'b1;
        check_val("rstmid_enh", enh_conf_o, 0);
        check_val("rstmid_en_low", en_low_o, 1);
        check_val("rstmid_busy", busy_o, 0);
        check_val("rstmid_done", done_o, 0);
        check_val("rstmid_err", err_o, 0);
        check_val("rstmid_addr", mem_addr_o, 0);
        check_val("rstmid_data", mem_data_o, 0);
        check_val("rstmid_writes", wr_n - wb, 0);

        // Full depth: B3 left in the FIFO, then 1..63
        for (int i = 1; i < 64; i++) push(8'(i));
        wb = wr_n;
        pulse_start(7'd64);
        wait_done(200, ok);
        check_val("full_done", ok, 1);
        check_val("full_writes", wr_n - wb, 64);
        check_val("full_last_addr", last_addr, 63);
        check_val("full_d0", sram[0], 8'hB3);
        check_val("full_d32", sram[32], 8'h20);
        check_val("full_d63", sram[63], 8'h3F);
        check_val("full_run", en_low_o, 0);

        // Reload from RUN
        push(8'hC0); push(8'hC1);
        wb = wr_n;
        pulse_start(7'd2);
        check_val("reload_enh", enh_conf_o, 1);
        check_val("reload_en_low", en_low_o, 1);
        wait_done(20, ok);
        check_val("reload_done", ok, 1);
        check_val("reload_writes", wr_n - wb, 2);
        check_val("reload_d0", sram[0], 8'hC0);
        check_val("reload_d1", sram[1], 8'hC1);

        // Bad length in RUN keeps running
        pulse_start(7'd65);
        check_val("runbad_err", err_o, 1);
        check_val("runbad_en_low", en_low_o, 0);
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        check_val("final_en_low", en_low_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/funct_generator_loader.md
Name: funct_generator_loader

Overview:
- Host-side initiator for the function generator control FSM.
- Drains waveform samples from an upstream FIFO into the generator's sample RAM.
- Holds the generator in configuration (enh_conf_o=1) while loading, then starts generation (en_low_o=0). Stops it on request.
- Sits between the sample FIFO and the generator top. Its outputs drive the generator FSM's enh_conf_i and en_low_i.

Parameters:
- DW, 8, sample data width.
- AW, 6, sample RAM address width (depth 2^AW).
- TMO, 255, FIFO-starvation timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start_i  in  1  one-cycle request to (re)load and run.
- stop_i  in  1  one-cycle request to stop generation or abort a load.
- len_i  in  AW+1  number of samples to load; sampled on start_i.
- fifo_empty_i  in  1  upstream FIFO empty flag.
- fifo_data_i  in  DW  FIFO read data, valid the cycle after the pop.
- fifo_rd_o  out  1  FIFO pop strobe.
- mem_we_o  out  1  sample RAM write enable.
- mem_addr_o  out  AW  sample RAM write address.
- mem_data_o  out  DW  sample RAM write data.
- enh_conf_o  out  1  to generator enh_conf_i; high = configure.
- en_low_o  out  1  to generator en_low_i; low = generate.
- busy_o  out  1  high in LOAD.
- done_o  out  1  one-cycle pulse when the load completes.
- err_o  out  1  one-cycle pulse on a bad length (or timeout).

Behaviour:
- One clock. Synchronous active-low reset rst_n; all state is updated only on the rising edge of clk.
- Reset values:
  - state=IDLE; all counters 0.
  - fifo_rd_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0.
  - enh_conf_o=0, en_low_o=1, busy_o=0, done_o=0, err_o=0.
- Reset mid-LOAD discards the pending pop and does not write.
- States: IDLE, LOAD, RUN.
- IDLE (enh_conf_o=0, en_low_o=1):
  - start_i with 1 <= len_i <= 2^AW: latch len, clear rd_cnt/wr_cnt, go to LOAD.
  - start_i with len_i=0 or len_i > 2^AW: err_o pulses next cycle; stay in IDLE.
- LOAD (enh_conf_o=1, en_low_o=1, busy_o=1):
  - fifo_rd_o is combinational: LOAD && !fifo_empty_i && rd_cnt < len && !stop_i.
  - Each pop increments rd_cnt.
  - rd_q is fifo_rd_o registered. When rd_q=1: mem_we_o=1, mem_addr_o=wr_cnt[AW-1:0], mem_data_o=fifo_data_i (combinational pass-through); wr_cnt increments.
  - Write latency: 1 cycle after the pop. Maximum throughput: 1 sample per cycle.
  - Last write (wr_cnt = len-1 and rd_q=1): next state RUN; done_o=1 for that next cycle.
  - A FIFO that goes empty only stalls the load; there is no error without the optional feature.
- RUN (enh_conf_o=0, en_low_o=0):
  - stop_i: go to IDLE.
  - start_i (without stop_i): same length checks as IDLE. A valid length reloads via LOAD; the generator enters CONFI because enh_conf has priority there.
  - A bad length pulses err_o and the block stays in RUN.
- stop_i in LOAD: abort to IDLE next cycle.
  - A pop already issued (rd_q=1) still writes in the abort cycle.
  - No further pops; done_o is not pulsed.
- Simultaneous start_i and stop_i: stop wins in every state.
- len = 2^AW: wr_cnt reaches 2^AW-1; mem_addr_o does not wrap before completion.
- Outputs enh_conf_o, en_low_o, busy_o, done_o and err_o are registered. fifo_rd_o and mem_data_o are combinational.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - A starvation counter counts cycles in LOAD with fifo_empty_i=1 and rd_cnt < len. It clears on any pop.
  - When the counter reaches TMO: go to IDLE, pulse err_o, assert no further pops.
- Undefined: no counter exists; LOAD waits indefinitely.

Decomposition:
- Package funct_generator_pkg holds:
  - enum loader_state_t {IDLE, LOAD, RUN} (2 bits).
  - Default widths DW_DEF=8, AW_DEF=6.
  - Function len_ok(len, aw).
- Sub-module loader_cnt: an up-counter with clear and enable, width AW+1. It is instantiated for rd_cnt and wr_cnt, and for the timeout counter when enabled.

Test Plan:
- Basic load: reset, FIFO holds 0x10..0x13, start_i with len_i=4.
  - fifo_rd_o high 4 consecutive cycles.
  - mem_we_o at addr 0..3 with data 0x10..0x13.
  - enh_conf_o=1 throughout LOAD; done_o pulses once; then en_low_o=0 and enh_conf_o=0.
- Bad length: start_i with len_i=0, then len_i=65 (AW=6).
  - err_o pulses each time; state stays IDLE; no pop.
- Starved FIFO: len_i=3 with only 1 sample present; push 2 more after 10 cycles.
  - Writes at addr 0, then 1 and 2 after the refill; done_o pulses.
  - With LOADER_TIMEOUT_EN and TMO=5, the 2nd sample never arrives: err_o pulses after 5 empty cycles; state returns to IDLE.
- Abort and priority:
  - stop_i in LOAD after 2 pops: exactly 2 writes, IDLE, no done_o.
  - start_i and stop_i together in RUN: IDLE, en_low_o=1.
- Full depth and reload: len_i=64 load completes with last write at addr 63.
  - start_i in RUN with len_i=2 reloads addr 0..1; enh_conf_o rises the next cycle.
- Reset mid-LOAD: rst_n=0 for one cycle with rd_q=1.
  - No write; all outputs at their reset values.
